// File: rtl/cpu_datapath.sv
// Register-file/ALU datapath for the small controller CPU: 16 general registers,
// a four-way ALU, a four-way write mux and a registered {carry, negative, zero} flag word.
module cpu_datapath #(
    parameter int DW   = 16,
    parameter int NREG = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [7:0]    RF_W_data,
    input  logic          RF_s1,
    input  logic          RF_s0,
    input  logic [3:0]    RF_W_addr,
    input  logic          RF_W_wr,
    input  logic [3:0]    RF_Rp_addr,
    input  logic          RF_Rp_rd,
    input  logic [3:0]    RF_Rq_addr,
    input  logic          RF_Rq_rd,
    input  logic          alu_s1,
    input  logic          alu_s0,
    input  logic [DW-1:0] D_R_data,
    output logic [DW-1:0] D_W_data,
    output logic          RF_Rp_zero,
    output logic [2:0]    flags
);

    localparam logic [1:0] ALU_PASS = 2'b00;
    localparam logic [1:0] ALU_ADD  = 2'b01;
    localparam logic [1:0] ALU_SUB  = 2'b10;

    localparam logic [1:0] WSEL_ALU   = 2'b00;
    localparam logic [1:0] WSEL_MEM   = 2'b01;
    localparam logic [1:0] WSEL_CONST = 2'b10;

    logic [DW-1:0] regs [NREG];
    logic [DW-1:0] p_data;
    logic [DW-1:0] q_data;
    logic [DW:0]   alu_wide;
    logic [DW-1:0] alu_result;
    logic          alu_carry;
    logic [DW-1:0] wr_data;
    logic [1:0]    alu_sel;
    logic [1:0]    wr_sel;
    logic          wr_en;
    logic          flag_update;
    logic [2:0]    flags_q;

    assign alu_sel = {alu_s1, alu_s0};
    assign wr_sel  = {RF_s1, RF_s0};

    // Enables are tested with an if so that an unknown rd/wr falls through to "off".
    always_comb begin
        p_data = '0;
        if (RF_Rp_rd == 1'b1) begin
            p_data = regs[RF_Rp_addr];
        end
    end

    always_comb begin
        q_data = '0;
        if (RF_Rq_rd == 1'b1) begin
            q_data = regs[RF_Rq_addr];
        end
    end

    always_comb begin
        wr_en = 1'b0;
        if (RF_W_wr == 1'b1) begin
            wr_en = 1'b1;
        end
    end

    // One extra bit holds the carry on add and the borrow on subtract.
    always_comb begin
        alu_wide = {1'b0, p_data};
        case (alu_sel)
            ALU_ADD: alu_wide = {1'b0, p_data} + {1'b0, q_data};
            ALU_SUB: alu_wide = {1'b0, p_data} - {1'b0, q_data};
            default: alu_wide = {1'b0, p_data};
        endcase
    end

    assign alu_result = alu_wide[DW-1:0];
    assign alu_carry  = alu_wide[DW];

    always_comb begin
        wr_data = '0;
        case (wr_sel)
            WSEL_ALU:   wr_data = alu_result;
            WSEL_MEM:   wr_data = D_R_data;
            WSEL_CONST: wr_data = {{(DW-8){RF_W_data[7]}}, RF_W_data};
            default:    wr_data = '0;
        endcase
    end

    assign flag_update = wr_en && (wr_sel == WSEL_ALU) &&
                         ((alu_sel == ALU_ADD) || (alu_sel == ALU_SUB));

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
            flags_q <= 3'b000;
        end else begin
            if (wr_en) begin
                regs[RF_W_addr] <= wr_data;
            end
            if (flag_update) begin
                flags_q <= {alu_carry, alu_result[DW-1], (alu_result == '0)};
            end
        end
    end

    assign D_W_data   = p_data;
    assign RF_Rp_zero = (p_data == '0);
    assign flags      = flags_q;

    logic unused_pass;
    assign unused_pass = (alu_sel == ALU_PASS);

endmodule

// File: tb/tb_cpu_datapath.sv
// Self-checking bench for cpu_datapath: directed register/ALU/flag scenarios followed
// by a short random instruction mix checked against a behavioural register model.
module tb_cpu_datapath;

    localparam int DW = 16;

    logic          clk;
    logic          rst;
    logic [7:0]    RF_W_data;
    logic          RF_s1;
    logic          RF_s0;
    logic [3:0]    RF_W_addr;
    logic          RF_W_wr;
    logic [3:0]    RF_Rp_addr;
    logic          RF_Rp_rd;
    logic [3:0]    RF_Rq_addr;
    logic          RF_Rq_rd;
    logic          alu_s1;
    logic          alu_s0;
    logic [DW-1:0] D_R_data;
    logic [DW-1:0] D_W_data;
    logic          RF_Rp_zero;
    logic [2:0]    flags;

    cpu_datapath #(.DW(DW), .NREG(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .RF_W_data  (RF_W_data),
        .RF_s1      (RF_s1),
        .RF_s0      (RF_s0),
        .RF_W_addr  (RF_W_addr),
        .RF_W_wr    (RF_W_wr),
        .RF_Rp_addr (RF_Rp_addr),
        .RF_Rp_rd   (RF_Rp_rd),
        .RF_Rq_addr (RF_Rq_addr),
        .RF_Rq_rd   (RF_Rq_rd),
        .alu_s1     (alu_s1),
        .alu_s0     (alu_s0),
        .D_R_data   (D_R_data),
        .D_W_data   (D_W_data),
        .RF_Rp_zero (RF_Rp_zero),
        .flags      (flags)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] model [16];
    logic [2:0]    model_flags;

    task automatic check(input string tag, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // driver tasks
    task automatic set_idle();
        RF_W_data  = 8'h00;
        RF_s1      = 1'b0;
        RF_s0      = 1'b0;
        RF_W_addr  = 4'h0;
        RF_W_wr    = 1'b0;
        RF_Rp_addr = 4'h0;
        RF_Rp_rd   = 1'b0;
        RF_Rq_addr = 4'h0;
        RF_Rq_rd   = 1'b0;
        alu_s1     = 1'b0;
        alu_s0     = 1'b0;
        D_R_data   = '0;
    endtask

    task automatic op_write(input logic [3:0] wa, input logic [1:0] s, input logic [1:0] alu,
                            input logic [3:0] pa, input logic [3:0] qa,
                            input logic [7:0] wd, input logic [DW-1:0] dr);
        RF_W_addr  = wa;
        {RF_s1, RF_s0}   = s;
        {alu_s1, alu_s0} = alu;
        RF_Rp_addr = pa;
        RF_Rq_addr = qa;
        RF_Rp_rd   = 1'b1;
        RF_Rq_rd   = 1'b1;
        RF_W_data  = wd;
        D_R_data   = dr;
        RF_W_wr    = 1'b1;
        @(posedge clk);
        #1;
        set_idle();
    endtask

    // scoreboard: pop one expected port-P value and compare data and zero flag
    task automatic sb_compare(input string tag);
        logic [DW-1:0] e;
        if (exp_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL %s: scoreboard queue empty", tag);
        end else begin
            e = exp_q.pop_front();
            check({tag, "_data"}, D_W_data, e);
            check({tag, "_zero"}, {{(DW-1){1'b0}}, RF_Rp_zero}, {{(DW-1){1'b0}}, (e == '0)});
            check({tag, "_nox"}, {{(DW-1){1'b0}}, $isunknown({D_W_data, RF_Rp_zero})}, '0);
        end
    endtask

    task automatic read_p(input string tag, input logic [3:0] a, input logic [DW-1:0] exp);
        RF_Rp_rd   = 1'b1;
        RF_Rp_addr = a;
        exp_q.push_back(exp);
        @(negedge clk);
        sb_compare(tag);
        @(posedge clk);
        #1;
        set_idle();
    endtask

    task automatic read_off(input string tag, input logic rd, input logic [3:0] a);
        RF_Rp_rd   = rd;
        RF_Rp_addr = a;
        exp_q.push_back('0);
        @(negedge clk);
        sb_compare(tag);
        @(posedge clk);
        #1;
        set_idle();
    endtask

    task automatic check_flags(input string tag, input logic [2:0] exp);
        check(tag, {{(DW-3){1'b0}}, flags}, {{(DW-3){1'b0}}, exp});
    endtask

    initial begin
        logic      x_bit;
        int        op;
        logic [3:0] wa, pa, qa;
        logic [7:0] wd;
        logic [DW-1:0] dr, pv, qv, res;
        logic [DW:0]   wide;

        set_idle();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_flags("rst_flags", 3'b000);
        rst = 1'b0;

        for (int i = 0; i < 16; i++) begin
            read_p("rst_reg", i[3:0], '0);
        end

        // constants and sign extension
        op_write(4'd3, 2'b10, 2'b00, 4'd0, 4'd0, 8'hF6, '0);
        read_p("const_r3", 4'd3, 16'hFFF6);
        op_write(4'd4, 2'b10, 2'b00, 4'd0, 4'd0, 8'h05, '0);
        read_p("const_r4", 4'd4, 16'h0005);
        check_flags("const_flags", 3'b000);

        // add: negative result, then wrap to zero with carry
        op_write(4'd5, 2'b00, 2'b01, 4'd3, 4'd4, 8'h00, '0);
        read_p("add_r5", 4'd5, 16'hFFFB);
        check_flags("add1_flags", 3'b010);
        op_write(4'd3, 2'b10, 2'b00, 4'd0, 4'd0, 8'hFB, '0);
        check_flags("const_keeps_flags", 3'b010);
        op_write(4'd6, 2'b00, 2'b01, 4'd4, 4'd3, 8'h00, '0);
        read_p("add_r6", 4'd6, 16'h0000);
        check_flags("add2_flags", 3'b101);

        // subtract with borrow, then to zero
        op_write(4'd7, 2'b00, 2'b10, 4'd4, 4'd5, 8'h00, '0);
        read_p("sub_r7", 4'd7, 16'h000A);
        check_flags("sub1_flags", 3'b100);
        op_write(4'd8, 2'b00, 2'b10, 4'd4, 4'd4, 8'h00, '0);
        check_flags("sub2_flags", 3'b001);
        read_p("sub_r8", 4'd8, 16'h0000);

        // memory load while reading the same register: old value first
        RF_W_wr = 1'b1; RF_W_addr = 4'd9; {RF_s1, RF_s0} = 2'b01; D_R_data = 16'h1234;
        RF_Rp_rd = 1'b1; RF_Rp_addr = 4'd9;
        exp_q.push_back(16'h0000);
        @(negedge clk);
        sb_compare("load_old");
        @(posedge clk);
        #1;
        set_idle();
        read_p("load_new", 4'd9, 16'h1234);
        check_flags("load_flags", 3'b001);

        // pass selects (00 and reserved 11) and the zero write source
        op_write(4'd10, 2'b00, 2'b11, 4'd7, 4'd4, 8'h00, '0);
        read_p("pass11_r10", 4'd10, 16'h000A);
        op_write(4'd11, 2'b00, 2'b00, 4'd9, 4'd4, 8'h00, '0);
        read_p("pass00_r11", 4'd11, 16'h1234);
        check_flags("pass_flags", 3'b001);
        op_write(4'd7, 2'b11, 2'b01, 4'd9, 4'd9, 8'h7F, 16'hBEEF);
        read_p("zero_sel_r7", 4'd7, 16'h0000);
        check_flags("zero_sel_flags", 3'b001);

        // reset beats a same-edge write
        op_write(4'd2, 2'b10, 2'b00, 4'd0, 4'd0, 8'h07, '0);
        read_p("pre_rst_r2", 4'd2, 16'h0007);
        RF_W_wr = 1'b1; RF_W_addr = 4'd2; {RF_s1, RF_s0} = 2'b10; RF_W_data = 8'h09;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        set_idle();
        read_p("rst_wr_r2", 4'd2, 16'h0000);
        check_flags("rst_wr_flags", 3'b000);
        read_p("rst_r9", 4'd9, 16'h0000);

        // disabled / unknown read enable yields zero
        op_write(4'd2, 2'b10, 2'b00, 4'd0, 4'd0, 8'h03, '0);
        read_p("r2_set", 4'd2, 16'h0003);
        read_off("rp_off", 1'b0, 4'd2);
        x_bit = 1'bx;
        if ($isunknown(x_bit)) begin
            read_off("rp_x", x_bit, 4'd2);
        end

        // random instruction mix against a register model
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 16; i++) model[i] = '0;
        model_flags = 3'b000;
        for (int n = 0; n < 40; n++) begin
            op = $urandom_range(0, 5);
            wa = 4'($urandom_range(0, 15));
            pa = 4'($urandom_range(0, 15));
            qa = 4'($urandom_range(0, 15));
            wd = 8'($urandom_range(0, 255));
            dr = DW'($urandom_range(0, 65535));
            pv = model[pa];
            qv = model[qa];
            case (op)
                0: begin
                    model[wa] = {{(DW-8){wd[7]}}, wd};
                    op_write(wa, 2'b10, 2'b00, pa, qa, wd, dr);
                end
                1: begin
                    model[wa] = dr;
                    op_write(wa, 2'b01, 2'b10, pa, qa, wd, dr);
                end
                2, 3: begin
                    wide = (op == 2) ? ({1'b0, pv} + {1'b0, qv}) : ({1'b0, pv} - {1'b0, qv});
                    res = wide[DW-1:0];
                    model[wa] = res;
                    model_flags = {wide[DW], res[DW-1], (res == '0)};
                    op_write(wa, 2'b00, (op == 2) ? 2'b01 : 2'b10, pa, qa, wd, dr);
                end
                4: begin
                    model[wa] = pv;
                    op_write(wa, 2'b00, 2'b11, pa, qa, wd, dr);
                end
                default: begin
                    model[wa] = '0;
                    op_write(wa, 2'b11, 2'b01, pa, qa, wd, dr);
                end
            endcase
            check_flags("rnd_flags", model_flags);
            read_p("rnd_wr", wa, model[wa]);
        end
        for (int i = 0; i < 16; i++) begin
            read_p("rnd_final", i[3:0], model[i]);
        end

        // final report
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/cpu_datapath.md
Name: cpu_datapath

Overview:
Register-file/ALU datapath directly downstream of the controller FSM. Consumes its RF and ALU control outputs, the 8-bit constant field and data-memory read data. Produces data-memory write data and the combinational RF_Rp_zero flag the controller samples in its jump-if-zero state. Holds 16 general registers plus a registered status-flag word.

Parameters:
DW, 16, datapath/register width (≥ 9)
NREG, 16, number of registers (address width fixed at 4)

Ports:
clk  in  1  clock, all state updates on posedge
rst  in  1  synchronous, active-high reset
RF_W_data  in  8  constant field (instruction[7:0])
RF_s1  in  1  write-mux select, high bit
RF_s0  in  1  write-mux select, low bit
RF_W_addr  in  4  write register address
RF_W_wr  in  1  write enable
RF_Rp_addr  in  4  read port P address
RF_Rp_rd  in  1  read port P enable
RF_Rq_addr  in  4  read port Q address
RF_Rq_rd  in  1  read port Q enable
alu_s1  in  1  ALU select, high bit
alu_s0  in  1  ALU select, low bit
D_R_data  in  DW  data-memory read data
D_W_data  out  DW  data-memory write data (= port P value)
RF_Rp_zero  out  1  port P value == 0 (combinational)
flags  out  3  registered {carry, negative, zero} of last ALU write

Behaviour:
- Interface fixed: one clock `clk`; reset `rst` is synchronous and active-high.
- Reset: on posedge with rst=1, all NREG registers <= 0 and flags <= 3'b000. A write presented in the same cycle is discarded; rst has priority.
- Read ports are asynchronous. Pdata = (RF_Rp_rd===1) ? R[RF_Rp_addr] : 0. Qdata is the same with the Q signals.
- rd/addr inputs may be X when unused. Any rd value other than 1 is treated as 0, so X never propagates to D_W_data or RF_Rp_zero.
- D_W_data = Pdata. RF_Rp_zero = (Pdata == 0). RF_Rp_zero is therefore 1 whenever port P is disabled. The controller only samples it in its JZ state.
- ALU, selected by {alu_s1,alu_s0}:
  - 00 passes Pdata.
  - 01 computes Pdata+Qdata.
  - 10 computes Pdata−Qdata.
  - 11 passes Pdata (reserved).
  - Arithmetic is computed DW+1 bits wide. Result is the low DW bits. Carry is bit DW. For subtract, carry = borrow (1 when P<Q unsigned).
- Write mux, selected by {RF_s1,RF_s0}:
  - 00 selects the ALU result.
  - 01 selects D_R_data.
  - 10 selects RF_W_data sign-extended to DW.
  - 11 selects 0.
- Write: on posedge with rst=0 and RF_W_wr===1, R[RF_W_addr] <= mux output. Mux selects are only guaranteed valid when RF_W_wr=1.
- There is no read-after-write bypass. A same-cycle read of the written register returns the old value; the new value is visible the next cycle.
- Simultaneous read and write of one address: reads see the old value; the write lands at the edge.
- Flags update only on a write cycle with mux select 00 and alu select 01 or 10:
  - zero = (result == 0)
  - negative = result[DW-1]
  - carry = ALU carry/borrow
  - Otherwise flags hold.
- Load/const writes do not touch flags.
- Wrap-around: add/sub are modulo 2^DW with no saturation.
- Reset mid-operation: any pending write is lost. Registers read 0 from the first cycle after reset.

Test Plan:
- Reset then read all 16 regs on P and Q -> all 0, RF_Rp_zero=1, flags=000.
- Const write s=10, W_data=8'hF6 to R3; next cycle read R3 -> 16'hFFF6. Const 8'h05 to R4 -> 16'h0005, flags unchanged.
- Add R5=R3+R4 (alu=01, s=00) -> R5=16'hFFFB, flags {c=0,n=1,z=0}. Then R6=R4+R3 with R3 rewritten to 16'hFFFB -> R6=0, flags {1,0,1}.
- Subtract R7=R4−R5 (5−0xFFFB) -> 16'h000A, borrow: flags {1,0,0}. R8=R4−R4 -> 0, flags {0,0,1}, and reading R8 on P gives RF_Rp_zero=1.
- Load s=01, D_R_data=16'h1234, addr 9, while reading R9 on P the same cycle -> D_W_data old value 0; next cycle 16'h1234.
- Write R2 with rst=1 the same edge -> R2 stays 0. Rp_rd=X or 0 with R2 nonzero -> D_W_data=0, RF_Rp_zero=1, no X on outputs.
